// File: rtl/pm1_stage1_sequencer_if.sv
// pm1_stage1_sequencer_if: valid/ready job channel from the sequencer to the modexp unit
interface pm1_stage1_sequencer_if;
  logic job_valid;
  logic job_ready;
  logic [8:0] job_base;
  logic [7:0] job_exp;
  modport master (output job_valid, job_base, job_exp, input job_ready);
  modport slave (input job_valid, job_base, job_exp, output job_ready);
endinterface

// File: rtl/pm1_stage1_sequencer.sv
// pm1_stage1_sequencer: stage-1 Pollard p-1 controller walking the prime table and issuing (p, e) power jobs
module pm1_stage1_sequencer #(
  parameter int ADDR_W = 6,
  parameter int FIND_TIMEOUT = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [7:0] bound,
  output logic busy,
  output logic done,
  output logic error,
  output logic [ADDR_W:0] job_count,
  output logic [ADDR_W-1:0] prime_addr,
  input  logic [8:0] prime_data,
  output logic [7:0] fe_boundary,
  output logic [8:0] fe_base,
  output logic fe_enable,
  input  logic [7:0] fe_exponent,
  input  logic fe_ready,
  pm1_stage1_sequencer_if.master job
);
  typedef enum logic [2:0] {IDLE, FETCH, FIND, ISSUE, GAP, DONE} state_t;
  localparam int CW = $clog2(FIND_TIMEOUT + GAP_CYCLES + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] b_r, e_r;
  logic [8:0] p_r;
  logic fetch_end, stop, find_ok, find_to, gap_end, last;
  always_comb begin
    fetch_end = state == FETCH && cnt == CW'(1);
    stop = prime_data == 9'd0 || prime_data > {1'b0, b_r};
    find_ok = state == FIND && cnt != '0 && fe_ready;
    find_to = state == FIND && !find_ok && cnt == CW'(FIND_TIMEOUT - 1);
    gap_end = state == GAP && cnt == CW'(GAP_CYCLES - 1);
    last = &prime_addr;
    state_n = state;
    case (state)
      IDLE: state_n = start ? FETCH : IDLE;
      FETCH: state_n = fetch_end ? (stop ? DONE : FIND) : FETCH;
      FIND: state_n = find_ok ? ISSUE : find_to ? DONE : FIND;
      ISSUE: state_n = job.job_ready ? GAP : ISSUE;
      GAP: state_n = gap_end ? (last ? DONE : FETCH) : GAP;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      b_r <= '0;
      p_r <= '0;
      e_r <= '0;
      error <= 1'b0;
      job_count <= '0;
      prime_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + CW'(1);
      if (state == IDLE && start) begin
        b_r <= bound;
        prime_addr <= '0;
        job_count <= '0;
        error <= 1'b0;
      end
      if (fetch_end) p_r <= prime_data;
      if (find_ok) e_r <= fe_exponent;
      if (find_to) error <= 1'b1;
      if (state == ISSUE && job.job_ready) job_count <= job_count + (ADDR_W+1)'(1);
      if (gap_end && !last) prime_addr <= prime_addr + ADDR_W'(1);
    end
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign fe_enable = state == FIND;
  assign fe_base = p_r;
  assign fe_boundary = b_r;
  assign job.job_valid = state == ISSUE;
  assign job.job_base = p_r;
  assign job.job_exp = e_r;
endmodule
